// File: rtl/risc_pkg.sv
// ---------------------------------------------------------------------------
// risc_pkg
//   Shared RV32I decode definitions for the decode stage and its register
//   file: datapath sizing, major opcode constants, ALU operation classes,
//   the immediate-format selector and the registered control bundle type.
//   The helper imm_gen() builds the 32-bit immediate for a given format.
// ---------------------------------------------------------------------------
package risc_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU operation class handed to execute
    localparam logic [1:0] ALUOP_ADD    = 2'd0;  // load/store address, LUI
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_RTYPE  = 2'd2;
    localparam logic [1:0] ALUOP_IALU   = 2'd3;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U
    } imm_fmt_e;

    // Control half of the decode bundle (data operands are kept separately
    // because their width follows the XLEN parameter of the stage).
    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
        logic [9:0] funct;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       illegal;
    } dec_ctrl_t;

    function automatic logic [31:0] imm_gen(input imm_fmt_e fmt, input logic [31:0] instr);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// ---------------------------------------------------------------------------
// decode_regfile
//   NREGS x XLEN architectural register file: two combinational read ports
//   and one synchronous write port. x0 always reads zero and writes to it
//   are dropped. Contents are deliberately not reset.
// Ports
//   clk      clock
//   we_i     write strobe
//   waddr_i  write register index
//   wdata_i  write value
//   raddr_i  read indices, [0] = rs1, [1] = rs2
//   rdata_o  read values,  [0] = rs1, [1] = rs2
// ---------------------------------------------------------------------------
module decode_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [XLEN-1:0]      wdata_i,
    input  logic [1:0][AW-1:0]   raddr_i,
    output logic [1:0][XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [NREGS];

    always_ff @(posedge clk) begin
        if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // x0 is forced at the read side since its storage is never written
    // and never reset.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        assign rdata_o[gi] = (raddr_i[gi] == '0) ? '0 : mem_q[raddr_i[gi]];
    end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   RV32I instruction decode. Accepts instruction words from fetch over
//   valid/ready, reads rs1/rs2 from the register file (written by
//   writeback) and presents a registered decode bundle to execute over
//   valid/ready with one cycle of latency. flush kills the registered
//   bundle and any same-cycle input; srst-style rst overrides flush.
//   Optional macro DECODE_WB_BYPASS_EN: a read of a register being written
//   back in the same cycle returns the writeback value instead of the old
//   contents.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   fetch handshake, in_instr = instruction word
//   flush               discard bundle and same-cycle input
//   wb_en/wb_addr/wb_data  register file write port
//   out_valid/out_ready execute handshake
//   out_in1/out_in2     rs1 (0 for LUI) / rs2 operand values
//   out_immgen          sign-extended immediate
//   out_alusrc/out_aluop/out_funct  ALU control
//   out_rd/out_regwrite destination and write enable
//   out_memread/out_memwrite/out_branch/out_illegal  class flags
// ---------------------------------------------------------------------------
module decode_stage
    import risc_pkg::*;
#(
    parameter int XLEN  = risc_pkg::XLEN,
    parameter int NREGS = risc_pkg::NREGS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_in1,
    output logic [XLEN-1:0] out_in2,
    output logic [XLEN-1:0] out_immgen,
    output logic            out_alusrc,
    output logic [1:0]      out_aluop,
    output logic [9:0]      out_funct,
    output logic [4:0]      out_rd,
    output logic            out_regwrite,
    output logic            out_memread,
    output logic            out_memwrite,
    output logic            out_branch,
    output logic            out_illegal
);

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [1:0][REG_AW-1:0] rs_addr;

    assign opcode     = in_instr[6:0];
    assign rd         = in_instr[11:7];
    assign funct3     = in_instr[14:12];
    assign rs_addr[0] = in_instr[19:15];
    assign rs_addr[1] = in_instr[24:20];
    assign funct7     = in_instr[31:25];

    // Register file and read-side bypass
    logic [1:0][XLEN-1:0] rf_rdata;
    logic [1:0][XLEN-1:0] rs_val;

    decode_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .we_i    (wb_en),
        .waddr_i (wb_addr),
        .wdata_i (wb_data),
        .raddr_i (rs_addr),
        .rdata_o (rf_rdata)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_rs
`ifdef DECODE_WB_BYPASS_EN
        // wb_addr != 0 keeps a write to x0 from leaking into an x0 read.
        assign rs_val[gi] = (wb_en && (wb_addr != '0) && (wb_addr == rs_addr[gi]))
                            ? wb_data : rf_rdata[gi];
`else
        assign rs_val[gi] = rf_rdata[gi];
`endif
    end

    // Combinational decode
    dec_ctrl_t       ctrl_d;
    imm_fmt_e        imm_fmt;
    logic            zero_in1;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] in1_d;

    always_comb begin
        ctrl_d       = '0;
        ctrl_d.funct = {7'b0, funct3};
        imm_fmt      = IMM_NONE;
        zero_in1     = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_d.aluop    = ALUOP_RTYPE;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.funct    = {funct7, funct3};
            end
            OP_IALU: begin
                ctrl_d.aluop    = ALUOP_IALU;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                imm_fmt         = IMM_I;
                // Only the shifts carry meaning in funct7 (SRLI vs SRAI);
                // for other I-ALU ops those bits are immediate.
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    ctrl_d.funct = {funct7, funct3};
                end
            end
            OP_LOAD: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memread  = 1'b1;
                ctrl_d.regwrite = 1'b1;
                imm_fmt         = IMM_I;
            end
            OP_STORE: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memwrite = 1'b1;
                imm_fmt         = IMM_S;
            end
            OP_BRANCH: begin
                ctrl_d.aluop  = ALUOP_BRANCH;
                ctrl_d.branch = 1'b1;
                imm_fmt       = IMM_B;
            end
            OP_LUI: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                imm_fmt         = IMM_U;
                zero_in1        = 1'b1;
            end
            default: begin
                ctrl_d.illegal = 1'b1;
            end
        endcase

        // A write to x0 is no write at all; rd is only meaningful with regwrite.
        if (rd == 5'd0) begin
            ctrl_d.regwrite = 1'b0;
        end
        ctrl_d.rd = ctrl_d.regwrite ? rd : 5'd0;
    end

    assign imm_d = XLEN'($signed(imm_gen(imm_fmt, in_instr)));
    assign in1_d = zero_in1 ? '0 : rs_val[0];

    // Output register / handshake
    logic            valid_q;
    dec_ctrl_t       ctrl_q;
    logic [XLEN-1:0] in1_q;
    logic [XLEN-1:0] in2_q;
    logic [XLEN-1:0] imm_q;
    logic            transfer;

    assign in_ready = !valid_q || out_ready;
    assign transfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            imm_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (transfer) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            in1_q   <= in1_d;
            in2_q   <= rs_val[1];
            imm_q   <= imm_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid    = valid_q;
    assign out_in1      = in1_q;
    assign out_in2      = in2_q;
    assign out_immgen   = imm_q;
    assign out_alusrc   = ctrl_q.alusrc;
    assign out_aluop    = ctrl_q.aluop;
    assign out_funct    = ctrl_q.funct;
    assign out_rd       = ctrl_q.rd;
    assign out_regwrite = ctrl_q.regwrite;
    assign out_memread  = ctrl_q.memread;
    assign out_memwrite = ctrl_q.memwrite;
    assign out_branch   = ctrl_q.branch;
    assign out_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage. Each comparison is an immediate
//   assertion; one line is printed per decoded instruction.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_in1;
    logic [31:0] out_in2;
    logic [31:0] out_immgen;
    logic        out_alusrc;
    logic [1:0]  out_aluop;
    logic [9:0]  out_funct;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic        out_memread;
    logic        out_memwrite;
    logic        out_branch;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    // Bench-side copy of the register contents it has written.
    logic [31:0] rf_model [32];
    logic [31:0] exp_same_cycle;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .flush        (flush),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_in1      (out_in1),
        .out_in2      (out_in2),
        .out_immgen   (out_immgen),
        .out_alusrc   (out_alusrc),
        .out_aluop    (out_aluop),
        .out_funct    (out_funct),
        .out_rd       (out_rd),
        .out_regwrite (out_regwrite),
        .out_memread  (out_memread),
        .out_memwrite (out_memwrite),
        .out_branch   (out_branch),
        .out_illegal  (out_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_bundle(input string tag,
                                 input logic [31:0] e_in1, input logic [31:0] e_in2,
                                 input logic [31:0] e_imm, input logic e_alusrc,
                                 input logic [1:0] e_aluop, input logic [9:0] e_funct,
                                 input logic [4:0] e_rd, input logic e_rw,
                                 input logic e_mr, input logic e_mw,
                                 input logic e_br, input logic e_ill);
        chk({tag, ".in1"},      out_in1,      e_in1);
        chk({tag, ".in2"},      out_in2,      e_in2);
        chk({tag, ".immgen"},   out_immgen,   e_imm);
        chk({tag, ".alusrc"},   32'(out_alusrc),   32'(e_alusrc));
        chk({tag, ".aluop"},    32'(out_aluop),    32'(e_aluop));
        chk({tag, ".funct"},    32'(out_funct),    32'(e_funct));
        chk({tag, ".rd"},       32'(out_rd),       32'(e_rd));
        chk({tag, ".regwrite"}, 32'(out_regwrite), 32'(e_rw));
        chk({tag, ".memread"},  32'(out_memread),  32'(e_mr));
        chk({tag, ".memwrite"}, 32'(out_memwrite), 32'(e_mw));
        chk({tag, ".branch"},   32'(out_branch),   32'(e_br));
        chk({tag, ".illegal"},  32'(out_illegal),  32'(e_ill));
        $display("[%0t] %s: in1=%08h in2=%08h imm=%08h aluop=%0d funct=%03h rd=%0d",
                 $time, tag, out_in1, out_in2, out_immgen, out_aluop, out_funct, out_rd);
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        tick();
        wb_en = 1'b0;
        if (addr != 5'd0) rf_model[addr] = data;
    endtask

    // One-cycle transfer; bundle is visible when this returns.
    task automatic send(input logic [31:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
        chk("send.out_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        wb_en     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'h0;
        out_ready = 1'b0;
        rf_model[0] = 32'h0;

        // Reset
        repeat (2) tick();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        expect_bundle("rst", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 10'h0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);
        chk("post_rst.out_valid", 32'(out_valid), 32'd0);

        // Known contents in every register
        for (int i = 1; i < 32; i++) wb(5'(i), 32'hA000_0000 | 32'(i));
        out_ready = 1'b1;

        // add x3,x5,x5
        wb(5'd5, 32'h1234);
        in_valid = 1'b1;
        in_instr = 32'h005281B3;
        #1;
        chk("add.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("add.out_valid", 32'(out_valid), 32'd1);
        expect_bundle("add", 32'h1234, 32'h1234, 32'h0, 1'b0, 2'd2, 10'h000, 5'd3,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("add.drain", 32'(out_valid), 32'd0);

        // addi x1,x0,-1 then beq x0,x0,-4 back to back
        send(32'hFFF00093);
        expect_bundle("addi", 32'h0, rf_model[31], 32'hFFFF_FFFF, 1'b1, 2'd3, 10'h000, 5'd1,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'hFE000EE3);
        expect_bundle("beq", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0, 2'd1, 10'h000, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure: bundle holds, input blocked
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0082A203;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall.in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("stall.out_valid", 32'(out_valid), 32'd1);
            chk("stall.immgen", out_immgen, 32'hFFFF_FFFC);
            chk("stall.branch", 32'(out_branch), 32'd1);
            chk("stall.aluop", 32'(out_aluop), 32'd1);
        end
        $display("[%0t] stall: bundle held for 3 cycles", $time);

        // Flush with a same-cycle accepted input
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("flush.in_ready", 32'(in_ready), 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("flush.dropped", 32'(out_valid), 32'd0);
        $display("[%0t] flush: bundle and same-cycle input discarded", $time);

        // lw x4,8(x5)
        send(32'h0082A203);
        expect_bundle("lw", 32'h1234, rf_model[8], 32'h8, 1'b1, 2'd0, 10'h002, 5'd4,
                      1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // sw x5,-8(x0)
        send(32'hFE502C23);
        expect_bundle("sw", 32'h0, 32'h1234, 32'hFFFF_FFF8, 1'b1, 2'd0, 10'h002, 5'd0,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // lui x6,0xABCDE
        send(32'hABCDE337);
        expect_bundle("lui", 32'h0, rf_model[28], 32'hABCD_E000, 1'b1, 2'd0, 10'h006, 5'd6,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // srai x11,x5,3 keeps funct7
        send(32'h4032D593);
        expect_bundle("srai", 32'h1234, rf_model[3], 32'h0000_0403, 1'b1, 2'd3, 10'h105, 5'd11,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // andi x12,x5,0x7FF has funct7 zeroed
        send(32'h7FF2F613);
        expect_bundle("andi", 32'h1234, rf_model[31], 32'h0000_07FF, 1'b1, 2'd3, 10'h007, 5'd12,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("alu.drain", 32'(out_valid), 32'd0);

        // Writeback and read of x7 in the same cycle
        wb(5'd7, 32'h55);
        wb_en   = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'hAA;
        send(32'h00038433);            // add x8,x7,x0
        wb_en = 1'b0;
        rf_model[7] = 32'hAA;
`ifdef DECODE_WB_BYPASS_EN
        exp_same_cycle = 32'hAA;
`else
        exp_same_cycle = 32'h55;
`endif
        chk("wbsame.in1", out_in1, exp_same_cycle);
        chk("wbsame.rd", 32'(out_rd), 32'd8);
        $display("[%0t] wbsame: in1=%08h", $time, out_in1);
        send(32'h000384B3);            // add x9,x7,x0
        chk("wbafter.in1", out_in1, 32'hAA);
        $display("[%0t] wbafter: in1=%08h", $time, out_in1);

        // Writes to x0 are dropped, same cycle and after
        wb_en   = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'hFF;
        send(32'h00000533);            // add x10,x0,x0
        wb_en = 1'b0;
        chk("x0same.in1", out_in1, 32'h0);
        chk("x0same.in2", out_in2, 32'h0);
        send(32'h00000533);
        chk("x0after.in1", out_in1, 32'h0);
        chk("x0after.in2", out_in2, 32'h0);
        $display("[%0t] x0: in1=%08h in2=%08h", $time, out_in1, out_in2);

        // Unsupported opcode still handshakes
        #1;
        chk("jal.in_ready", 32'(in_ready), 32'd1);
        send(32'h0000006F);
        expect_bundle("jal", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 10'h000, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("jal.consumed", 32'(out_valid), 32'd0);

        // Reset while a bundle is waiting
        out_ready = 1'b0;
        send(32'h0082A203);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        expect_bundle("midrst", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 10'h0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("midrst.in_ready", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
